// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the Wishbone target RAM.
// Queue entries use the widest supported fields; narrower instances zero-extend into them.
package wb_pkg;

  localparam int unsigned AddrMaxWidth = 32;
  localparam int unsigned DataMaxWidth = 64;
  localparam int unsigned SelMaxWidth  = 8;

  typedef struct packed {
    logic                    we;
    logic [AddrMaxWidth-1:0] addr;
    logic [SelMaxWidth-1:0]  sel;
    logic [DataMaxWidth-1:0] dat;
    logic                    tag;
  } req_entry_t;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  function automatic int unsigned sel_width(input int unsigned dw, input int unsigned gran);
    return dw / gran;
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// In-order request queue with synchronous flush; Depth must be a power of two.
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntWidth = idx_width(Depth) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  req_entry_t          din,
  output req_entry_t          dout,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  localparam int unsigned PtrWidth = idx_width(Depth);

  req_entry_t          mem [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntWidth'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wishbone_target_ram.sv
// Pipelined Wishbone target: queued requests served in order from a lane-writable RAM.
// Define WB_TARGET_RANGE_ERR_EN to answer ADDR >= Depth with ERR instead of wrapping.
module wishbone_target_ram
  import wb_pkg::*;
#(
  parameter int unsigned AddressWidth = 16,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Granularity  = 8,
  parameter int unsigned Depth        = 256,
  parameter int unsigned WaitStates   = 1,
  parameter int unsigned QueueDepth   = 4,
  localparam int unsigned SELWidth    = sel_width(DataWidth, Granularity)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [AddressWidth-1:0] ADDR,
  input  logic [SELWidth-1:0]     SEL,
  input  logic [DataWidth-1:0]    DAT_ToTarget,
  input  logic                    TGD_ToTarget,
  output logic [DataWidth-1:0]    DAT_ToInitiator,
  output logic                    TGD_ToInitiator,
  output logic                    ACK,
  output logic                    ERR,
  output logic                    RTY,
  output logic                    STALL
);

  localparam int unsigned IdxWidth = idx_width(Depth);
  localparam int unsigned CntWidth = idx_width(QueueDepth) + 1;
  localparam logic [3:0]  WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
  localparam bit          NoWait   = (WaitStates == 0);
  localparam logic [AddrMaxWidth:0] DepthLimit = (AddrMaxWidth + 1)'(Depth);

  logic [DataWidth-1:0] ram [Depth];
  req_entry_t           push_entry, head;
  logic                 push, pop, full, empty;
  logic [CntWidth-1:0]  count;
  state_e               state_q;
  logic [3:0]           wait_cnt_q;
  logic [IdxWidth-1:0]  ram_idx;
  logic                 out_of_range, range_err, do_resp, ram_we;

  always_comb begin
    push_entry      = '0;
    push_entry.we   = WE;
    push_entry.addr = AddrMaxWidth'(ADDR);
    push_entry.sel  = SelMaxWidth'(SEL);
    push_entry.dat  = DataMaxWidth'(DAT_ToTarget);
    push_entry.tag  = TGD_ToTarget;
  end

  assign push  = CYC & STB & ~full;
  assign STALL = full;
  assign RTY   = 1'b0;

  wb_req_fifo #(
    .Depth (QueueDepth)
  ) u_req_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .flush (~CYC),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ram_idx      = head.addr[IdxWidth-1:0];
  assign out_of_range = ({1'b0, head.addr} >= DepthLimit);
`ifdef WB_TARGET_RANGE_ERR_EN
  assign range_err = out_of_range;
`else
  assign range_err = 1'b0;
`endif

  // The response is registered on the edge that enters StResp, so StResp is the ACK cycle.
  assign do_resp = CYC & ((state_q == StWait && wait_cnt_q == 4'd0) ||
                          (NoWait && !empty && state_q != StWait));
  assign pop     = do_resp;
  assign ram_we  = do_resp & head.we & ~range_err;

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int l = 0; l < SELWidth; l++) begin
        if (head.sel[l]) begin
          ram[ram_idx][l*Granularity +: Granularity] <= head.dat[l*Granularity +: Granularity];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= StIdle;
      wait_cnt_q      <= 4'd0;
      ACK             <= 1'b0;
      ERR             <= 1'b0;
      DAT_ToInitiator <= '0;
      TGD_ToInitiator <= 1'b0;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      if (!CYC) begin
        state_q <= StIdle;
      end else if (do_resp) begin
        state_q         <= StResp;
        TGD_ToInitiator <= head.tag;
        if (range_err) begin
          ERR             <= 1'b1;
          DAT_ToInitiator <= '0;
        end else begin
          ACK             <= 1'b1;
          DAT_ToInitiator <= head.we ? '0 : ram[ram_idx];
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!empty) begin
              state_q    <= StWait;
              wait_cnt_q <= WaitLoad;
            end
          end
          StWait: wait_cnt_q <= wait_cnt_q - 4'd1;
          StResp: begin
            if (!empty) begin
              state_q    <= StWait;
              wait_cnt_q <= WaitLoad;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{head, count, out_of_range};

endmodule

// File: tb/tb_wishbone_target_ram.sv
// Directed bench for wishbone_target_ram at default parameters (WaitStates=1, QueueDepth=4).
module tb_wishbone_target_ram;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CYC = 1'b0;
  logic        STB = 1'b0;
  logic        WE  = 1'b0;
  logic [15:0] ADDR = '0;
  logic [3:0]  SEL = '0;
  logic [31:0] DAT_ToTarget = '0;
  logic        TGD_ToTarget = 1'b0;
  logic [31:0] DAT_ToInitiator;
  logic        TGD_ToInitiator, ACK, ERR, RTY, STALL;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wishbone_target_ram #(
    .AddressWidth (16),
    .DataWidth    (32),
    .Granularity  (8),
    .Depth        (256),
    .WaitStates   (1),
    .QueueDepth   (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .CYC             (CYC),
    .STB             (STB),
    .WE              (WE),
    .ADDR            (ADDR),
    .SEL             (SEL),
    .DAT_ToTarget    (DAT_ToTarget),
    .TGD_ToTarget    (TGD_ToTarget),
    .DAT_ToInitiator (DAT_ToInitiator),
    .TGD_ToInitiator (TGD_ToInitiator),
    .ACK             (ACK),
    .ERR             (ERR),
    .RTY             (RTY),
    .STALL           (STALL)
  );

  task automatic drive(input logic we, input logic [15:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic t);
    STB = 1'b1; WE = we; ADDR = a; SEL = s; DAT_ToTarget = d; TGD_ToTarget = t;
  endtask

  // One request accepted on the next rising edge; returns 1 ns after that edge.
  task automatic req(input logic we, input logic [15:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic t);
    @(negedge CLK);
    drive(we, a, s, d, t);
    @(posedge CLK);
    #1;
    STB = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    CYC = 1'b0;
    #12;
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ACK); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ERR); end
    checks++; if (RTY !== 1'b0) begin errors++; $display("FAIL rst_rty got %b want 0", RTY); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", STALL); end
    checks++; if (DAT_ToInitiator !== 32'h0) begin
      errors++; $display("FAIL rst_dat got %h want 0", DAT_ToInitiator);
    end
    checks++; if (TGD_ToInitiator !== 1'b0) begin
      errors++; $display("FAIL rst_tgd got %b want 0", TGD_ToInitiator);
    end
    @(negedge CLK);
    RST = 1'b1;
    CYC = 1'b1;
  endtask

  task automatic test_write_read;
    req(1'b1, 16'd5, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1);
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %b want 0", ACK); end
    step(1);
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", ACK); end
    checks++; if (DAT_ToInitiator !== 32'h0) begin
      errors++; $display("FAIL wr_dat_zero got %h want 0", DAT_ToInitiator);
    end
    checks++; if (TGD_ToInitiator !== 1'b1) begin
      errors++; $display("FAIL wr_tgd got %b want 1", TGD_ToInitiator);
    end
    step(1);
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", ACK); end
    req(1'b0, 16'd5, 4'hF, 32'h0, 1'b0);
    step(1);
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL rd_ack_early got %b want 0", ACK); end
    step(1);
    checks++; if (ACK !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL rd_ack got ack=%b err=%b want ack=1 err=0", ACK, ERR);
    end
    checks++; if (DAT_ToInitiator !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_dat got %h want deadbeef", DAT_ToInitiator);
    end
    checks++; if (TGD_ToInitiator !== 1'b0) begin
      errors++; $display("FAIL rd_tgd got %b want 0", TGD_ToInitiator);
    end
  endtask

  task automatic test_partial_write;
    req(1'b1, 16'd5, 4'h1, 32'h000000AA, 1'b1);
    step(2);
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL pw_ack got %b want 1", ACK); end
    req(1'b0, 16'd5, 4'hF, 32'h0, 1'b1);
    step(2);
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'hDEADBEAA) begin
      errors++; $display("FAIL pw_dat got ack=%b dat=%h want ack=1 dat=deadbeaa",
                         ACK, DAT_ToInitiator);
    end
  endtask

  task automatic test_back_to_back;
    int   k = 0;
    int   acks = 0;
    logic stall_before;
    logic saw_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 16'(10 + i), 4'hF, 32'hA5A50000 + 32'(i), 1'b0);
      step(2);
      checks++; if (ACK !== 1'b1) begin
        errors++; $display("FAIL preload_ack idx %0d got %b want 1", i, ACK);
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (k < 6) drive(1'b0, 16'(10 + k), 4'hF, 32'h0, k[0]);
      else STB = 1'b0;
      stall_before = STALL;
      if (STALL === 1'b1) saw_stall = 1'b1;
      @(posedge CLK);
      #1;
      if (STB === 1'b1 && stall_before === 1'b0) begin
        k++;
        if (k == 6) begin
          checks++; if (STALL !== 1'b1) begin
            errors++; $display("FAIL b2b_stall_full got %b want 1", STALL);
          end
        end
      end
      if (ACK === 1'b1 || ERR === 1'b1) begin
        checks++;
        if (ACK !== 1'b1 || acks >= 6 || DAT_ToInitiator !== 32'hA5A50000 + 32'(acks) ||
            TGD_ToInitiator !== acks[0]) begin
          errors++;
          $display("FAIL b2b_resp #%0d got ack=%b dat=%h tgd=%b want ack=1 dat=%h tgd=%b",
                   acks, ACK, DAT_ToInitiator, TGD_ToInitiator, 32'hA5A50000 + 32'(acks),
                   acks[0]);
        end
        acks++;
      end
    end
    STB = 1'b0;
    checks++; if (k !== 6) begin errors++; $display("FAIL b2b_accepts got %0d want 6", k); end
    checks++; if (acks !== 6) begin errors++; $display("FAIL b2b_acks got %0d want 6", acks); end
    checks++; if (saw_stall !== 1'b1) begin
      errors++; $display("FAIL b2b_saw_stall got %b want 1", saw_stall);
    end
    checks++; if (STALL !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_drain got %b want 0", STALL);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1'b0, 16'(10 + i), 4'hF, 32'h0, 1'b1);
      @(posedge CLK);
    end
    @(negedge CLK);
    STB = 1'b0;
    CYC = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (ACK !== 1'b0 || ERR !== 1'b0 || STALL !== 1'b0) begin
      errors++; $display("FAIL flush_edge got ack=%b err=%b stall=%b want 0 0 0", ACK, ERR, STALL);
    end
    @(negedge CLK);
    CYC = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK);
      #1;
      checks++; if (ACK !== 1'b0 || ERR !== 1'b0 || STALL !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet cyc %0d got ack=%b err=%b stall=%b want 0 0 0",
                 c, ACK, ERR, STALL);
      end
    end
    req(1'b0, 16'd11, 4'hF, 32'h0, 1'b0);
    step(1);
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL flush_next_early got %b want 0", ACK); end
    step(1);
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'hA5A50001) begin
      errors++; $display("FAIL flush_next got ack=%b dat=%h want ack=1 dat=a5a50001",
                         ACK, DAT_ToInitiator);
    end
  endtask

  task automatic test_range;
    req(1'b1, 16'd44, 4'hF, 32'h44444444, 1'b0);
    step(2);
    req(1'b1, 16'd300, 4'hF, 32'h12345678, 1'b1);
    step(2);
`ifdef WB_TARGET_RANGE_ERR_EN
    checks++; if (ERR !== 1'b1 || ACK !== 1'b0) begin
      errors++; $display("FAIL range_wr got ack=%b err=%b want ack=0 err=1", ACK, ERR);
    end
`else
    checks++; if (ACK !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL range_wr got ack=%b err=%b want ack=1 err=0", ACK, ERR);
    end
`endif
    req(1'b0, 16'd300, 4'hF, 32'h0, 1'b1);
    step(1);
    checks++; if (ACK !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL range_rd_early got ack=%b err=%b want 0 0", ACK, ERR);
    end
    step(1);
`ifdef WB_TARGET_RANGE_ERR_EN
    checks++; if (ERR !== 1'b1 || ACK !== 1'b0 || DAT_ToInitiator !== 32'h0) begin
      errors++; $display("FAIL range_rd got ack=%b err=%b dat=%h want ack=0 err=1 dat=0",
                         ACK, ERR, DAT_ToInitiator);
    end
`else
    checks++; if (ACK !== 1'b1 || ERR !== 1'b0 || DAT_ToInitiator !== 32'h12345678) begin
      errors++; $display("FAIL range_rd got ack=%b err=%b dat=%h want ack=1 err=0 dat=12345678",
                         ACK, ERR, DAT_ToInitiator);
    end
`endif
    checks++; if (TGD_ToInitiator !== 1'b1) begin
      errors++; $display("FAIL range_tgd got %b want 1", TGD_ToInitiator);
    end
    step(1);
    checks++; if (ACK !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL range_pulse got ack=%b err=%b want 0 0", ACK, ERR);
    end
    req(1'b0, 16'd44, 4'hF, 32'h0, 1'b0);
    step(2);
`ifdef WB_TARGET_RANGE_ERR_EN
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'h44444444) begin
      errors++; $display("FAIL range_w44 got ack=%b dat=%h want ack=1 dat=44444444",
                         ACK, DAT_ToInitiator);
    end
`else
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'h12345678) begin
      errors++; $display("FAIL range_w44 got ack=%b dat=%h want ack=1 dat=12345678",
                         ACK, DAT_ToInitiator);
    end
`endif
  endtask

  task automatic test_reset_mid;
    req(1'b1, 16'd7, 4'hF, 32'hCAFEF00D, 1'b0);
    step(2);
    req(1'b0, 16'd7, 4'hF, 32'h0, 1'b1);
    step(2);
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'hCAFEF00D || TGD_ToInitiator !== 1'b1) begin
      errors++; $display("FAIL rm_pre got ack=%b dat=%h tgd=%b want 1 cafef00d 1",
                         ACK, DAT_ToInitiator, TGD_ToInitiator);
    end
    req(1'b0, 16'd7, 4'hF, 32'h0, 1'b1);
    step(1);
    #2;
    RST = 1'b0;
    #1;
    checks++; if (ACK !== 1'b0 || ERR !== 1'b0 || RTY !== 1'b0 || STALL !== 1'b0) begin
      errors++; $display("FAIL rm_ctrl got ack=%b err=%b rty=%b stall=%b want 0 0 0 0",
                         ACK, ERR, RTY, STALL);
    end
    checks++; if (DAT_ToInitiator !== 32'h0 || TGD_ToInitiator !== 1'b0) begin
      errors++; $display("FAIL rm_data got dat=%h tgd=%b want 0 0", DAT_ToInitiator,
                         TGD_ToInitiator);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      checks++; if (ACK !== 1'b0 || ERR !== 1'b0) begin
        errors++; $display("FAIL rm_dropped cyc %0d got ack=%b err=%b want 0 0", c, ACK, ERR);
      end
    end
    req(1'b0, 16'd7, 4'hF, 32'h0, 1'b0);
    step(2);
    checks++; if (ACK !== 1'b1 || DAT_ToInitiator !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rm_post got ack=%b dat=%h want ack=1 dat=cafef00d",
                         ACK, DAT_ToInitiator);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_flush();
    test_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
